// File: rtl/display_pkg.sv
// Shared types and constants for the parking-display scan controller:
// scan FSM encoding and the active-low 7-segment glyph table.
package display_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Active-low segments {g,f,e,d,c,b,a}; entry 15 (code F) is blank.
  localparam logic [15:0][6:0] SEG_LUT = {
    SEG_BLANK, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78,     7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational map from a 4-bit digit code to active-low segments g..a.
module seven_seg_decoder
  import display_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = SEG_LUT[code_i];

endmodule

// File: rtl/parking_display_scanner.sv
// Time-multiplexed scan controller for the vacancy 7-segment bank: per-slot
// blanking window, frame-aligned digit updates, all outputs registered.
module parking_display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV_WIDTH    = 18,
  parameter int SCAN_DIV     = 65536,
  parameter int BLANK_CYCLES = 1024
) (
  input  logic                    clk_internal,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic                    frame_done,
  output scan_state_e             dbg_state
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  scan_state_e                     state_q, state_d;
  logic [DIV_WIDTH-1:0]            presc_q, presc_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]      act_dig_q, act_dig_d, pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0]           act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                            pend_full_q, pend_full_d;
  logic                            load_ready_q;
  logic [6:0]                      seg_n_q, seg_n_d, dec_seg;
  logic                            dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0]           dig_en_q, dig_en_d;
  logic                            frame_q, frame_d;
  logic                            slot_end, blank_end, last_dig, frame_wrap;
  logic                            drive, transfer, capture;

  assign slot_end   = (presc_q == DIV_WIDTH'(SCAN_DIV - 1));
  assign blank_end  = (presc_q == DIV_WIDTH'(BLANK_CYCLES - 1));
  assign last_dig   = (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign frame_wrap = enable && (state_q == ST_DRIVE) && slot_end && last_dig;
  assign drive      = enable && (state_q == ST_DRIVE);

  // Handshake: a set transfers into pending on load_valid && load_ready;
  // load_ready stays low until pending moves to the active buffer (frame
  // wrap, or any edge while OFF), so the source must hold its data meanwhile.
  assign capture  = load_valid && !pend_full_q;
  assign transfer = pend_full_q && (frame_wrap || (state_q == ST_OFF));

  seven_seg_decoder u_dec (
    .code_i  (act_dig_q[idx_q]),
    .seg_n_o (dec_seg)
  );

  always_comb begin
    state_d = state_q;
    presc_d = slot_end ? '0 : presc_q + DIV_WIDTH'(1);
    idx_d   = idx_q;
    if (!enable) begin
      state_d = ST_OFF;
      presc_d = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_BLANK;
          presc_d = '0;
          idx_d   = '0;
        end
        ST_BLANK: if (blank_end) state_d = ST_DRIVE;
        ST_DRIVE: if (slot_end) begin
          state_d = ST_BLANK;
          idx_d   = last_dig ? '0 : idx_q + IDX_W'(1);
        end
        default: begin
          state_d = ST_OFF;
          presc_d = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    act_dig_d   = act_dig_q;
    act_dp_d    = act_dp_q;
    pend_dig_d  = pend_dig_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;
    if (transfer) begin
      act_dig_d   = pend_dig_q;
      act_dp_d    = pend_dp_q;
      pend_full_d = 1'b0;
    end else if (capture) begin
      pend_dig_d  = digit_data;
      pend_dp_d   = dp_mask;
      pend_full_d = 1'b1;
    end
  end

  always_comb begin
    seg_n_d  = SEG_BLANK;
    dp_n_d   = 1'b1;
    dig_en_d = '1;
    frame_d  = frame_wrap;
    if (drive) begin
      seg_n_d         = dec_seg;
      dp_n_d          = ~act_dp_q[idx_q];
      dig_en_d[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge clk_internal or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_OFF;
      presc_q      <= '0;
      idx_q        <= '0;
      act_dig_q    <= {NUM_DIGITS{BLANK_CODE}};
      act_dp_q     <= '0;
      pend_dig_q   <= {NUM_DIGITS{BLANK_CODE}};
      pend_dp_q    <= '0;
      pend_full_q  <= 1'b0;
      load_ready_q <= 1'b1;
      seg_n_q      <= SEG_BLANK;
      dp_n_q       <= 1'b1;
      dig_en_q     <= '1;
      frame_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      act_dig_q    <= act_dig_d;
      act_dp_q     <= act_dp_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pend_full_q  <= pend_full_d;
      load_ready_q <= ~pend_full_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      dig_en_q     <= dig_en_d;
      frame_q      <= frame_d;
    end
  end

  assign load_ready = load_ready_q;
  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign digit_en_n = dig_en_q;
  assign frame_done = frame_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_parking_display_scanner.sv
// Bench for parking_display_scanner with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
// A cycle-time reference model predicts every registered output each clock.
module tb_parking_display_scanner;
  import display_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] digit_data;
  logic [3:0]  dp_mask;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  digit_en_n;
  logic        frame_done;
  scan_state_e dbg_state;

  int total = 0;
  int bad   = 0;

  // Reference model: time since scanning began, buffers as plain arrays.
  bit         m_run = 0;
  int         m_t = 0;
  bit         m_pend = 0;
  logic [3:0] m_pend_dig[4];
  logic [3:0] m_pend_dp;
  logic [3:0] m_act[4];
  logic [3:0] m_act_dp;
  bit         hs;

  typedef struct {
    logic [3:0] code;
    logic       dp;
    logic [6:0] seg;
  } vec_t;
  vec_t vecs[16];

  parking_display_scanner #(
    .NUM_DIGITS(4), .DIV_WIDTH(3), .SCAN_DIV(8), .BLANK_CYCLES(2)
  ) dut (
    .clk_internal (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .digit_data   (digit_data),
    .dp_mask      (dp_mask),
    .seg_n        (seg_n),
    .dp_n         (dp_n),
    .digit_en_n   (digit_en_n),
    .frame_done   (frame_done),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] lit;
    case (code)
      4'h0: lit = 7'h3F;  4'h1: lit = 7'h06;  4'h2: lit = 7'h5B;  4'h3: lit = 7'h4F;
      4'h4: lit = 7'h66;  4'h5: lit = 7'h6D;  4'h6: lit = 7'h7D;  4'h7: lit = 7'h07;
      4'h8: lit = 7'h7F;  4'h9: lit = 7'h6F;  4'hA: lit = 7'h77;  4'hB: lit = 7'h7C;
      4'hC: lit = 7'h39;  4'hD: lit = 7'h5E;  4'hE: lit = 7'h79;  default: lit = 7'h00;
    endcase
    return ~lit;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_t = 0; m_pend = 0; m_act_dp = 4'h0; m_pend_dp = 4'h0;
    for (int i = 0; i < 4; i++) begin m_act[i] = 4'hF; m_pend_dig[i] = 4'hF; end
  endtask

  task automatic tick();
    logic [6:0] e_seg;
    logic       e_dp, e_fd;
    logic [3:0] e_en;
    int         ph, dg;
    @(posedge clk);
    e_seg = 7'h7F; e_dp = 1'b1; e_en = 4'hF; e_fd = 1'b0;
    if (enable && m_run) begin
      ph = m_t % 8;
      dg = (m_t / 8) % 4;
      if (ph >= 2) begin
        e_en  = ~(4'b0001 << dg);
        e_seg = glyph(m_act[dg]);
        e_dp  = ~m_act_dp[dg];
      end
      e_fd = (m_t % 32 == 31);
    end
    hs = load_valid && !m_pend;
    if (m_pend && (!m_run || (enable && m_t % 32 == 31))) begin
      m_act = m_pend_dig; m_act_dp = m_pend_dp; m_pend = 0;
    end else if (hs) begin
      for (int i = 0; i < 4; i++) m_pend_dig[i] = digit_data[4*i +: 4];
      m_pend_dp = dp_mask; m_pend = 1;
    end
    if (!enable) begin m_run = 0; m_t = 0; end
    else if (!m_run) begin m_run = 1; m_t = 0; end
    else m_t++;
    #1;
    check("seg_n", {25'b0, seg_n}, {25'b0, e_seg});
    check("dp_n", {31'b0, dp_n}, {31'b0, e_dp});
    check("digit_en_n", {28'b0, digit_en_n}, {28'b0, e_en});
    check("frame_done", {31'b0, frame_done}, {31'b0, e_fd});
    check("load_ready", {31'b0, load_ready}, {31'b0, !m_pend});
    check("one_enable", ($countones(~digit_en_n) <= 1) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic load_digits(input logic [15:0] d, input logic [3:0] dp);
    int n = 0;
    load_valid = 1'b1; digit_data = d; dp_mask = dp;
    hs = 0;
    while (!hs && n < 100) begin tick(); n++; end
    check("load_accept", {31'b0, hs}, 32'd1);
    load_valid = 1'b0;
  endtask

  task automatic wait_xfer();
    int n = 0;
    while (m_pend && n < 80) begin tick(); n++; end
    check("xfer_done", {31'b0, m_pend}, 32'd0);
  endtask

  task automatic wait_en(input logic [3:0] pat, input string name);
    int n = 0;
    while (digit_en_n !== pat && n < 80) begin tick(); n++; end
    check(name, {28'b0, digit_en_n}, {28'b0, pat});
  endtask

  initial begin
    vecs[0]  = '{4'h0, 1'b0, 7'h40};  vecs[1]  = '{4'h1, 1'b1, 7'h79};
    vecs[2]  = '{4'h2, 1'b0, 7'h24};  vecs[3]  = '{4'h3, 1'b1, 7'h30};
    vecs[4]  = '{4'h4, 1'b0, 7'h19};  vecs[5]  = '{4'h5, 1'b1, 7'h12};
    vecs[6]  = '{4'h6, 1'b0, 7'h02};  vecs[7]  = '{4'h7, 1'b1, 7'h78};
    vecs[8]  = '{4'h8, 1'b0, 7'h00};  vecs[9]  = '{4'h9, 1'b1, 7'h10};
    vecs[10] = '{4'hA, 1'b0, 7'h08};  vecs[11] = '{4'hB, 1'b1, 7'h03};
    vecs[12] = '{4'hC, 1'b0, 7'h46};  vecs[13] = '{4'hD, 1'b1, 7'h21};
    vecs[14] = '{4'hE, 1'b0, 7'h06};  vecs[15] = '{4'hF, 1'b1, 7'h7F};

    model_reset();
    reset_n = 1'b0; enable = 1'b0; load_valid = 1'b0; digit_data = 16'h0; dp_mask = 4'h0;
    #12;
    check("rst_seg_n", {25'b0, seg_n}, 32'h7F);
    check("rst_dp_n", {31'b0, dp_n}, 32'd1);
    check("rst_digit_en_n", {28'b0, digit_en_n}, 32'hF);
    check("rst_load_ready", {31'b0, load_ready}, 32'd1);
    check("rst_frame_done", {31'b0, frame_done}, 32'd0);
    check("rst_state", {30'b0, dbg_state}, {30'b0, ST_OFF});
    @(posedge clk); #1 reset_n = 1'b1;

    // Free-running scan with nothing loaded.
    tick(); tick();
    enable = 1'b1;
    repeat (70) tick();

    // Mid-frame load, then a second offer while pending is full.
    load_digits(16'h1234, 4'b0100);
    load_valid = 1'b1; digit_data = 16'h5678; dp_mask = 4'b1111;
    repeat (5) tick();
    load_valid = 1'b0;
    wait_xfer();
    wait_en(4'b1110, "wait_d0_1234");
    check("seg_digit0_4", {25'b0, seg_n}, 32'h19);
    wait_en(4'b1011, "wait_d2_1234");
    check("seg_digit2_2", {25'b0, seg_n}, 32'h24);
    check("dp_digit2", {31'b0, dp_n}, 32'd0);
    repeat (40) tick();

    // Decode table: every code on all four digits.
    for (int v = 0; v < 16; v++) begin
      load_digits({4{vecs[v].code}}, {4{vecs[v].dp}});
      wait_xfer();
      wait_en(4'b1110, "wait_vec_d0");
      check("vec_seg", {25'b0, seg_n}, {25'b0, vecs[v].seg});
      check("vec_dp", {31'b0, dp_n}, {31'b0, ~vecs[v].dp});
    end

    // Random enable drops and load offers; source holds data until accepted.
    for (int c = 0; c < 800; c++) begin
      enable = ($urandom_range(0, 39) != 0);
      if (hs || !load_valid) begin
        load_valid = ($urandom_range(0, 3) == 0);
        digit_data = 16'($urandom);
        dp_mask    = 4'($urandom);
      end
      tick();
    end
    enable = 1'b1; load_valid = 1'b0;
    repeat (4) tick();

    // Disable during digit 2 drive, then restart from a blank slot 0.
    load_digits(16'h8888, 4'hF);
    wait_xfer();
    wait_en(4'b1011, "wait_d2_dis");
    enable = 1'b0;
    tick();
    check("dis_digit_en_n", {28'b0, digit_en_n}, 32'hF);
    check("dis_seg_n", {25'b0, seg_n}, 32'h7F);
    check("dis_dp_n", {31'b0, dp_n}, 32'd1);
    tick(); tick();
    enable = 1'b1;
    tick(); tick(); tick();
    check("restart_blank", {28'b0, digit_en_n}, 32'hF);
    tick();
    check("restart_d0", {28'b0, digit_en_n}, 32'hE);
    check("restart_seg", {25'b0, seg_n}, 32'h00);

    // Hex glyphs, blank code, then asynchronous reset mid-drive.
    load_digits(16'hFA0E, 4'h0);
    wait_xfer();
    wait_en(4'b1011, "wait_d2_fa0e");
    check("seg_digit2_A", {25'b0, seg_n}, 32'h08);
    wait_en(4'b0111, "wait_d3_fa0e");
    check("seg_digit3_blank", {25'b0, seg_n}, 32'h7F);
    wait_en(4'b1110, "wait_d0_fa0e");
    check("seg_digit0_E", {25'b0, seg_n}, 32'h06);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_seg_n", {25'b0, seg_n}, 32'h7F);
    check("async_rst_digit_en_n", {28'b0, digit_en_n}, 32'hF);
    check("async_rst_dp_n", {31'b0, dp_n}, 32'd1);
    check("async_rst_load_ready", {31'b0, load_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parking_display_scanner.md
Name: parking_display_scanner

Overview:
- Time-multiplexed scan controller for the parking-vacancy 7-segment display bank.
- Owns its own scan prescaler and steps one digit per scan slot.
- Inserts a blanking window at the start of each slot to suppress ghosting.
- Takes new vacancy digits through a valid/ready handshake and applies them only at frame boundaries, so the display never tears.
- Sits between the vacancy-count logic and the board's common-anode digit/segment pins.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits.
- DIV_WIDTH, 18: prescaler width.
- SCAN_DIV, 65536: clocks per digit slot. At 50 MHz this is ≈763 Hz per slot, ≈190 Hz per frame. Must be ≤ 2**DIV_WIDTH.
- BLANK_CYCLES, 1024: clocks at the start of each slot with all digits off. Must be ≥1 and < SCAN_DIV.

Ports:
- clk_internal  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = scan; 0 = display off.
- load_valid  in  1  new digit set offered.
- load_ready  out  1  pending buffer free; transfer on load_valid&&load_ready.
- digit_data  in  4*NUM_DIGITS  digit codes; digit i = [4i+3:4i], digit 0 rightmost.
- dp_mask  in  NUM_DIGITS  decimal-point enables, captured with digit_data.
- seg_n  out  7  segments g..a (bit6=g), active-low.
- dp_n  out  1  decimal point, active-low.
- digit_en_n  out  NUM_DIGITS  digit anode enables, active-low, at most one low at a time.
- frame_done  out  1  one-cycle pulse when the last digit's slot ends.

Behaviour:
- Reset values:
  - Outputs: seg_n=7'h7F, dp_n=1, digit_en_n=all 1, load_ready=1, frame_done=0.
  - Internal: state=OFF, prescaler=0, digit index=0, pending empty, active buffer = all 4'hF (blank) with dp off.
- All outputs are registered. Each output reflects the state/prescaler value of the previous cycle.
- Prescaler:
  - Counts 0..SCAN_DIV-1 while enable=1, then wraps to 0.
  - slot_end is asserted when prescaler == SCAN_DIV-1.
  - Prescaler is held at 0 when enable=0.
- FSM states: OFF, BLANK, DRIVE.
  - OFF: all outputs inactive. On enable=1, go to BLANK with index=0 and prescaler=0.
  - BLANK: digit_en_n all 1, seg_n=7'h7F. When prescaler == BLANK_CYCLES-1, go to DRIVE.
  - DRIVE: digit_en_n[index]=0; seg_n/dp_n show the decode of active digit[index]. On slot_end, go to BLANK and advance index; NUM_DIGITS-1 wraps to 0 and pulses frame_done.
  - From any state, enable=0 forces OFF on the next edge. Index and prescaler return to 0; pending and active buffers are kept.
- Decode:
  - 0-9: standard digits.
  - A-E: hex glyphs A, b, C, d, E.
  - F: blank, seg_n=7'h7F.
  - dp_n = ~dp of the active digit in DRIVE, else 1.
- Handshake:
  - On load_valid&&load_ready, capture digit_data/dp_mask into pending. load_ready=0 from the next cycle.
  - Pending→active transfer happens on the same edge as the wrap slot_end, or on the next edge while in OFF.
  - load_ready returns to 1 the cycle after transfer.
  - A transfer and a new capture never happen on the same edge.
  - load_valid while load_ready=0 is ignored; the source must hold its data.
- Reset mid-operation: outputs go to reset values immediately (asynchronously) and pending data is lost.

Decomposition:
- Shared package display_pkg holds:
  - state encoding (OFF/BLANK/DRIVE);
  - SEG_BLANK = 7'h7F;
  - BLANK_CODE = 4'hF;
  - 16-entry segment lookup constants.
- Sub-module: seven_seg_decoder, combinational, maps a 4-bit code to seg_n[6:0].

Test Plan:
- All tests use NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
- Reset release, then enable=1 with no load → digit_en_n cycles 1110→1101→1011→0111, each low for 6 of 8 cycles. seg_n=7'h7F throughout. frame_done pulses every 32 cycles.
- Load digit_data=16'h1234, dp_mask=4'b0100 mid-frame:
  - load_ready falls the next cycle; the display stays blank until frame_done.
  - Next frame: digit0 seg_n=7'b0011001 ("4"); digit2 seg_n=7'b0100100 ("2") with dp_n=0.
  - load_ready=1 again.
- Second load_valid while load_ready=0 → ignored; displayed value unchanged.
- Check slot timing: for every slot, the first 2 cycles after slot start have digit_en_n=4'hF, and no two enables are ever low together.
- enable=0 during a DRIVE of digit 2 → next cycle all outputs inactive. Re-enable restarts with a BLANK window for digit 0.
- Load codes 16'hFA0E → digit3 blank, digit2 "A" (7'b0001000), digit0 "E" (7'b0000110). Then assert reset_n=0 mid-DRIVE → seg_n=7'h7F and digit_en_n=4'hF with no clock edge.
